ritc_input_aligner: RTL
=======================

// Module: ritc_input_aligner
// PURPOSE
//  Per-channel word aligner between the RITC deserializers and the input sample-history shift register.
//  Raw NBITS words on channels A/B/C can be skewed by whole samples. Each channel realigns its stream
//  through a selectable sample offset. A training FSM finds the offset at which TRAIN_PATTERN appears.
//  The aligned, registered words drive the history stage's A_i/B_i/C_i inputs.
// PARAMETERS
//  NBITS         48         word width per channel; must equal NSAMP*SBITS
//  SBITS         3          bits per sample
//  NSAMP         16         samples per word; legal offsets 0..NSAMP-1; NSAMP <= 2**OFF_BITS
//  OFF_BITS      4          offset field width per channel
//  TRAIN_PATTERN 48'hB6DB6D_924924  aligned word expected during training
//  SETTLE        2          flush cycles after any offset change (>=1)
//  LOCK_COUNT    8          consecutive matches required for lock (1..255)
// PORTS
//  clk_i          in   1             system clock; all logic on rising edge
//  rst_i          in   1             asynchronous, active-high reset
//  A_i,B_i,C_i    in   NBITS each    raw deserialized words
//  train_i        in   1             1-cycle strobe; starts training on all 3 channels
//  offset_load_i  in   1             1-cycle strobe; loads offset_i into all channels
//  offset_i       in   3*OFF_BITS    manual offsets {C,B,A}
//  A_o,B_o,C_o    out  NBITS each    aligned words
//  offset_o       out  3*OFF_BITS    current offsets {C,B,A}
//  locked_o       out  3             per channel {C,B,A}: training succeeded
//  fail_o         out  3             per channel: training exhausted all offsets
//  busy_o         out  1             OR over channels of state in {SETTLE,CHECK}
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all outputs, prev regs, offsets and counters = 0; every FSM = IDLE.
//  Datapath, per channel:
//   - prev <= in each cycle; cat = {in, prev} (2*NBITS).
//   - out <= cat[off*SBITS +: NBITS].
//   - off=0 gives the previous word (2-cycle latency); off=k takes k newest samples from the current word.
//   - An offset change is visible on out 1 cycle after the offset register updates.
//  FSM, one per channel, independent:
//   - IDLE: train_i -> off=0, scnt=0, SETTLE; offset_load_i -> off=offset_i field, stay IDLE.
//   - SETTLE: scnt++; when scnt==SETTLE-1 -> CHECK with mcnt=0.
//   - CHECK, out==TRAIN_PATTERN: mcnt++; when mcnt==LOCK_COUNT-1 -> LOCKED.
//   - CHECK, mismatch with off<NSAMP-1: off++, scnt=0, SETTLE (mcnt cleared).
//   - CHECK, mismatch with off==NSAMP-1: -> FAIL (off stays NSAMP-1).
//   - LOCKED: locked bit=1, offset held, data not monitored. FAIL: fail bit=1.
//   - LOCKED/FAIL + train_i: clear locked/fail, off=0, -> SETTLE.
//   - LOCKED/FAIL + offset_load_i: clear locked/fail, load off, -> IDLE.
//   - train_i and offset_load_i in SETTLE/CHECK: ignored.
//   - train_i and offset_load_i in the same cycle: train_i wins.
//  Status timing:
//   - locked_o/fail_o update on the cycle after the state transition (registered).
//   - Worst-case lock at offset k: k*(SETTLE+1)+SETTLE+LOCK_COUNT+2 cycles after the train_i strobe.
//  Reset mid-training: immediate return to IDLE; no partial lock survives.
// TESTING
//  1. Reset asserted in CHECK at off=6 -> all outputs 0 asynchronously; IDLE; offset_o=0 after release.
//  2. Pattern at A=5, B=0, C=15, train_i pulse:
//     -> locked_o=3'b111, offset_o={4'd15,4'd0,4'd5}.
//     -> A locks within 27 cycles, C within 64 cycles; busy_o low afterwards.
//  3. Channel B fed constant 0, train_i -> fail_o[1]=1, locked_o[1]=0, B offset=15;
//     A/C still lock and are unaffected.
//  4. Pattern at offset 3 with one corrupted word on the 4th matching cycle:
//     -> offset advances to 4, scan continues, fail_o asserts after offset 15.
//  5. LOCKED at off=5, offset_load_i with offset_i={4'd7,4'd7,4'd7}:
//     -> offset_o all 7, locked_o=0, A_o = cat[21 +: 48] two cycles later.
//     Same cycle train_i+load -> training restarts at 0.
//  6. Manual off=0 then off=15 with ramp data -> A_o equals expected slice at 2-cycle latency;
//     no X on any output.

Source files
------------

// File: rtl/ritc_input_aligner.sv
// ritc_input_aligner: per-channel whole-sample word aligner with an offset-training FSM for the RITC deserializers
//   clk_i, rst_i        clock; asynchronous active-high reset
//   A_i, B_i, C_i       raw deserialized words
//   train_i             strobe: scan offsets on every channel until TRAIN_PATTERN is seen
//   offset_load_i       strobe: load offset_i {C,B,A} into every channel
//   A_o, B_o, C_o       registered aligned words
//   offset_o            current offsets {C,B,A}
//   locked_o, fail_o    per-channel training result {C,B,A}
//   busy_o              some channel is still settling or checking
module ritc_input_aligner #(
  parameter int                NBITS         = 48,
  parameter int                SBITS         = 3,
  parameter int                NSAMP         = 16,
  parameter int                OFF_BITS      = 4,
  parameter logic [NBITS-1:0]  TRAIN_PATTERN = 48'hB6DB6D_924924,
  parameter int                SETTLE        = 2,
  parameter int                LOCK_COUNT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NBITS-1:0]      A_i,
  input  logic [NBITS-1:0]      B_i,
  input  logic [NBITS-1:0]      C_i,
  input  logic                  train_i,
  input  logic                  offset_load_i,
  input  logic [3*OFF_BITS-1:0] offset_i,
  output logic [NBITS-1:0]      A_o,
  output logic [NBITS-1:0]      B_o,
  output logic [NBITS-1:0]      C_o,
  output logic [3*OFF_BITS-1:0] offset_o,
  output logic [2:0]            locked_o,
  output logic [2:0]            fail_o,
  output logic                  busy_o
);
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_LOCKED, ST_FAIL} state_t;
  logic [3*NBITS-1:0] raw, aligned;
  logic [2:0]         busy;
  assign raw = {C_i, B_i, A_i};
  assign {C_o, B_o, A_o} = aligned;
  assign busy_o = |busy;
  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t              state;
    logic [NBITS-1:0]    in_w, prev, out;
    logic [2*NBITS-1:0]  cat;
    logic [OFF_BITS-1:0] off, ld;
    logic [7:0]          scnt, mcnt;
    logic                locked, failed, busy_r, accept;
    assign in_w = raw[g*NBITS +: NBITS];
    assign cat = {in_w, prev};
    assign ld = offset_i[g*OFF_BITS +: OFF_BITS];
    // strobes are honoured only while the channel is not in the middle of a scan
    assign accept = state inside {ST_IDLE, ST_LOCKED, ST_FAIL};
    assign aligned[g*NBITS +: NBITS] = out;
    assign offset_o[g*OFF_BITS +: OFF_BITS] = off;
    assign locked_o[g] = locked;
    assign fail_o[g] = failed;
    assign busy[g] = busy_r;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state  <= ST_IDLE;
        prev   <= '0;
        out    <= '0;
        off    <= '0;
        scnt   <= '0;
        mcnt   <= '0;
        locked <= 1'b0;
        failed <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        prev   <= in_w;
        out    <= cat[int'(off)*SBITS +: NBITS];
        locked <= state == ST_LOCKED;
        failed <= state == ST_FAIL;
        busy_r <= state inside {ST_SETTLE, ST_CHECK};
        if (accept && train_i) begin
          off   <= '0;
          scnt  <= '0;
          state <= ST_SETTLE;
        end else if (accept && offset_load_i) begin
          off   <= ld;
          state <= ST_IDLE;
        end else if (state == ST_SETTLE) begin
          scnt <= scnt + 8'd1;
          if (scnt == 8'(SETTLE - 1)) begin
            mcnt  <= '0;
            state <= ST_CHECK;
          end
        end else if (state == ST_CHECK) begin
          if (out == TRAIN_PATTERN) begin
            mcnt <= mcnt + 8'd1;
            if (mcnt == 8'(LOCK_COUNT - 1)) state <= ST_LOCKED;
          end else if (off != OFF_BITS'(NSAMP - 1)) begin
            off   <= off + OFF_BITS'(1);
            scnt  <= '0;
            state <= ST_SETTLE;
          end else begin
            state <= ST_FAIL;
          end
        end
      end
    end
  end
endmodule
